sync_ff_multi: RTL and testbench
================================

SYNC_FF_MULTI -- requirements
Module: sync_ff_multi

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- WIDTH, 4, number of independent channels (1..32).
- STAGES, 2, synchroniser flop depth per channel (2..4).
- FILT_CNT, 3, consecutive stable cycles required before dout changes (1..255; 1 = no filtering).
- RST_VAL, {WIDTH{1'b0}}, reset value of the sync chain and of dout.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk_rx, input, 1, single receive-domain clock; all flops rise-edge.
- rst_rx_n, input, 1, asynchronous active-low reset.
- din, input, WIDTH, asynchronous channel inputs.
- filt_bypass, input, 1, quasi-static; 1 forces FILT_CNT behaviour of 1.
- dout, output, WIDTH, synchronised, filtered level.
- rise, output, WIDTH, one-cycle pulse per channel on dout 0->1.
- fall, output, WIDTH, one-cycle pulse per channel on dout 1->0.
- chg, output, 1, OR-reduction of rise|fall, same cycle.

REQ-003 The block SHALL use one clock (clk_rx) and an asynchronous, active-low reset (rst_rx_n); no other clock enters it.

Function
REQ-004 Each channel SHALL pass din[i] through a STAGES-deep flop chain s0..s(STAGES-1); sync_out[i] = s(STAGES-1)[i].
REQ-005 Each channel SHALL own a filter counter of width clog2(FILT_CNT+1).
- Each edge with sync_out[i] == dout[i]: cnt <= 0.
- Each edge with sync_out[i] != dout[i] and cnt < FILT_CNT-1: cnt <= cnt+1.
- Each edge with sync_out[i] != dout[i] and cnt == FILT_CNT-1: dout[i] <= sync_out[i], cnt <= 0.
REQ-006 With filt_bypass=1 or FILT_CNT=1, dout[i] SHALL load sync_out[i] on every edge, and all counters SHALL be held at 0.
REQ-007 Latency SHALL be L = STAGES+FILT_CNT rising edges for a stable din change, counting the capture edge into s0 as edge 1. With bypass, L = STAGES+1.
REQ-008 A sync_out excursion shorter than FILT_CNT cycles SHALL clear the counter and SHALL leave dout, rise and fall unchanged (glitch rejection).
REQ-009 rise[i] and fall[i] SHALL be registered and SHALL assert high for exactly the one cycle following the edge on which dout[i] changes. They SHALL never both be 1 for the same channel.
REQ-010 Channels SHALL be fully independent. Simultaneous changes on any subset SHALL produce simultaneous pulses. chg SHALL be combinational from the rise/fall registers.
REQ-011 A filt_bypass change SHALL take effect on the next edge. Partial counts SHALL be discarded when bypass is asserted.

Reset
REQ-012 While rst_rx_n = 0, the block SHALL hold:
- all sync flops and dout = RST_VAL;
- all counters = 0;
- rise = fall = 0 and chg = 0.
These values SHALL apply asynchronously, independent of clk_rx.
REQ-013 Reset asserted mid-count SHALL discard the count. After release, a pending change SHALL require the full L edges again.
REQ-014 Synchronous deassertion of rst_rx_n to clk_rx is the integrator's responsibility. The block SHALL function correctly from the first edge after release.

Verification (WIDTH=4, STAGES=2, FILT_CNT=3, RST_VAL=0, bypass=0 unless stated)
REQ-015 The bench SHALL cover these scenarios:
- rst_rx_n=0 with din=4'hF, clock running -> dout=4'h0, rise=fall=4'h0, chg=0 throughout.
- din[0] 0->1, held -> dout[0]=1 after edge 5; rise=4'b0001 for exactly one cycle; chg=1 that cycle only.
- din[1] high for 2 cycles, then low -> dout, rise and fall stay 4'h0 throughout.
- filt_bypass=1, din[2] 0->1 -> dout[2]=1 after edge 3; rise=4'b0100 for one cycle.
- dout=4'hF, din->4'h0 on all channels together -> dout=4'h0 after edge 5; fall=4'hF for one cycle; rise=4'h0.
- din[3] 0->1, rst_rx_n pulsed low after edge 3, din[3] held -> dout[3]=0 immediately; after release, dout[3]=1 only after 5 further edges.

Source files
------------

// File: rtl/sync_ff_multi.sv
// ============================================================================
//  Module   : sync_ff_multi
//  Brief    : Multi-channel level synchroniser with stability filter and
//             registered rise/fall edge pulses.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sync_ff_multi #(
    parameter int               WIDTH    = 4,
    parameter int               STAGES   = 2,
    parameter int               FILT_CNT = 3,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk_rx,
    input  logic             rst_rx_n,
    input  logic [WIDTH-1:0] din,
    input  logic             filt_bypass,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg
);

    localparam int             c_CNT_W    = $clog2(FILT_CNT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILT_CNT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic           c_NO_FILT  = (FILT_CNT == 1);

    logic [WIDTH-1:0]   sync_q [STAGES];
    logic [WIDTH-1:0]   sync_d [STAGES];
    logic [c_CNT_W-1:0] cnt_q  [WIDTH];
    logic [c_CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [WIDTH-1:0]   rise_q, rise_d;
    logic [WIDTH-1:0]   fall_q, fall_d;
    logic [WIDTH-1:0]   sync_out;
    logic               bypass;

    assign sync_out = sync_q[STAGES-1];
    assign bypass   = filt_bypass | c_NO_FILT;

    always_comb begin
        sync_d[0] = din;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // A channel's output only moves once sync_out has disagreed with it for
    // FILT_CNT consecutive edges; any agreement in between restarts the count.
    always_comb begin
        dout_d = dout_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (bypass) begin
                dout_d[i] = sync_out[i];
            end else if (sync_out[i] != dout_q[i]) begin
                if (cnt_q[i] == c_CNT_LAST) begin
                    dout_d[i] = sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + c_CNT_ONE;
                end
            end
        end
        rise_d = dout_d & ~dout_q;
        fall_d = ~dout_d & dout_q;
    end

    always_ff @(posedge clk_rx or negedge rst_rx_n) begin
        if (!rst_rx_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RST_VAL;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            dout_q <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign chg  = |(rise_q | fall_q);

endmodule

`default_nettype wire

// File: tb/tb_sync_ff_multi.sv
// ============================================================================
//  Module   : tb_sync_ff_multi
//  Brief    : Scoreboard bench for sync_ff_multi (WIDTH=4, STAGES=2, FILT_CNT=3).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sync_ff_multi;

    logic       clk_rx = 1'b0;
    logic       rst_rx_n;
    logic [3:0] din;
    logic       filt_bypass;
    logic [3:0] dout, rise, fall;
    logic       chg;

    typedef struct {
        int         cyc;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    sync_ff_multi #(
        .WIDTH   (4),
        .STAGES  (2),
        .FILT_CNT(3),
        .RST_VAL (4'h0)
    ) dut (
        .clk_rx     (clk_rx),
        .rst_rx_n   (rst_rx_n),
        .din        (din),
        .filt_bypass(filt_bypass),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .chg        (chg)
    );

    always #5 clk_rx = ~clk_rx;
    always @(posedge clk_rx) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] d, input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.cyc = c; e.dout = d; e.rise = r; e.fall = f;
        sb.push_back(e);
    endtask

    // Monitor: every pulse the DUT presents must match the oldest expectation.
    always @(negedge clk_rx) begin
        if (rst_rx_n === 1'b1 && chg === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: dout=%h rise=%h fall=%h (cycle %0d) expected no pulse",
                         dout, rise, fall, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.cyc || dout !== e.dout || rise !== e.rise || fall !== e.fall) begin
                    n_err++;
                    $display("FAIL pulse: cyc=%0d dout=%h rise=%h fall=%h expected cyc=%0d dout=%h rise=%h fall=%h",
                             cyc, dout, rise, fall, e.cyc, e.dout, e.rise, e.fall);
                end
            end
        end
        if (rst_rx_n === 1'b1 && (rise & fall) != 4'h0) begin
            n_err++;
            $display("FAIL rise_and_fall: rise=%h fall=%h expected disjoint", rise, fall);
        end
    end

    task automatic drive(input logic [3:0] v, output int n);
        @(negedge clk_rx);
        #1;
        din = v;
        n   = cyc;
    endtask

    initial begin
        int n;
        rst_rx_n    = 1'b0;
        din         = 4'hF;
        filt_bypass = 1'b0;

        // Reset held with all inputs high: outputs stay at reset value.
        repeat (4) begin
            @(negedge clk_rx);
            check("rst_dout", dout, 4'h0);
            check("rst_rise", rise, 4'h0);
            check("rst_fall", fall, 4'h0);
            check("rst_chg", chg, 1'b0);
        end
        din = 4'h0;
        @(negedge clk_rx);
        #1 rst_rx_n = 1'b1;
        repeat (3) @(negedge clk_rx);

        // Single channel rise, latency STAGES+FILT_CNT.
        drive(4'h1, n);
        push(n + 5, 4'h1, 4'h1, 4'h0);
        repeat (4) @(negedge clk_rx);
        check("ch0_before_latency", dout, 4'h0);
        repeat (4) @(negedge clk_rx);
        check("ch0_dout", dout, 4'h1);

        // Two-cycle glitch on channel 1 is rejected.
        drive(4'h3, n);
        drive(4'h3, n);
        drive(4'h1, n);
        repeat (8) begin
            @(negedge clk_rx);
            check("glitch_dout", dout, 4'h1);
        end

        // Bypass: latency STAGES+1.
        filt_bypass = 1'b1;
        drive(4'h5, n);
        push(n + 3, 4'h5, 4'h4, 4'h0);
        repeat (2) @(negedge clk_rx);
        check("byp_before", dout, 4'h1);
        repeat (4) @(negedge clk_rx);
        check("byp_dout", dout, 4'h5);
        filt_bypass = 1'b0;
        repeat (2) @(negedge clk_rx);

        // All channels high, then all low together.
        drive(4'hF, n);
        push(n + 5, 4'hF, 4'hA, 4'h0);
        repeat (8) @(negedge clk_rx);
        check("all_high", dout, 4'hF);
        drive(4'h0, n);
        push(n + 5, 4'h0, 4'h0, 4'hF);
        repeat (8) @(negedge clk_rx);
        check("all_low", dout, 4'h0);

        // Mid-count reset discards progress; channel 0 also cleared asynchronously.
        drive(4'h1, n);
        push(n + 5, 4'h1, 4'h1, 4'h0);
        repeat (8) @(negedge clk_rx);
        check("pre_rst_dout", dout, 4'h1);
        drive(4'h9, n);
        repeat (3) @(posedge clk_rx);
        #1 rst_rx_n = 1'b0;
        #1;
        check("async_rst_dout", dout, 4'h0);
        check("async_rst_rise", rise, 4'h0);
        check("async_rst_chg", chg, 1'b0);
        repeat (2) @(negedge clk_rx);
        check("rst_hold_dout", dout, 4'h0);
        #1 rst_rx_n = 1'b1;
        n = cyc;
        push(n + 5, 4'h9, 4'h9, 4'h0);
        repeat (4) @(negedge clk_rx);
        check("post_rst_wait", dout, 4'h0);
        repeat (4) @(negedge clk_rx);
        check("post_rst_dout", dout, 4'h9);

        repeat (3) @(negedge clk_rx);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
